e_mdu: RTL
==========

Name: e_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit in the E stage, alongside the single-cycle ALU.
- Executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Owns the architectural HI/LO registers and raises busy so the hazard unit can stall dependent MDU instructions.
- Honours a pending-exception request so that flushed instructions never modify HI/LO.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu; must be >=1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be >=1.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand 1 (rs).
- B  input  WIDTH  operand 2 (rt).
- MDUop  input  4  op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none.
- start  input  1  launch a mult/div op this cycle.
- req  input  1  exception/interrupt pending; suppresses all state changes from this cycle's op.
- busy  output  1  operation in flight.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.
- MDUresult  output  WIDTH  combinational: HI if MDUop=5, LO if MDUop=6, else 0.

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, busy=0, counter=0, pending result cleared. Reset mid-operation aborts the op; HI/LO become 0 and never receive the aborted result.
- Accept condition: start && !busy && !req && MDUop in {1,2,3,4}.
  - On the accepting edge the full result is computed from A/B and latched into pending registers.
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES.
- busy = (counter != 0).
  - Each subsequent edge decrements the counter.
  - On the edge where the counter goes 1->0, HI/LO are written from the pending registers.
  - Net effect: busy is high for exactly N cycles after the accept edge, and the new HI/LO are visible in the cycle busy falls.
- mult: signed 2*WIDTH product; HI = upper half, LO = lower half.
- multu: the same, unsigned.
- div: signed; LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign. Overflow case MIN / -1 gives LO=MIN, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (div/divu with B=0): accepted and busy for DIV_CYCLES, but HI/LO are left unchanged at completion.
- mthi/mtlo: write HI/LO from A on the edge, only when !busy && !req; otherwise ignored. They do not assert busy.
- start while busy: ignored. The in-flight op is unaffected and no new op is queued.
- start with MDUop not in 1-4: ignored.
- req with an op already in flight: the in-flight op continues and commits normally. req only blocks ops presented in the same cycle.
- mfhi/mflo: MDUresult reflects current HI/LO and is stale while busy. The hazard unit stalls on (busy || start) for any MDU op; the block itself does not check this.
- mthi/mtlo and the completion write never collide: completion only occurs while busy, and mthi/mtlo are ignored while busy.

Test Plan:
- Signed mult, MULT_CYCLES=5: A=0xFFFFFFFF, B=2, start=1 -> busy high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE in the cycle busy falls; HI/LO hold old values earlier.
- Unsigned mult: multu with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- Signed/unsigned divide, DIV_CYCLES=10:
  - div A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu of the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
  - div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero and ignored start:
  - mtlo A=0x1234 then divu A=7, B=0 -> busy 10 cycles, LO stays 0x1234.
  - A second start during busy is ignored; the busy length is unchanged.
- req suppression:
  - mult with req=1 -> busy stays 0 and HI/LO are unchanged.
  - mthi with req=1 -> HI unchanged.
  - req asserted mid-operation -> the op still commits on time.
- Reset and forwarding:
  - reset asserted on cycle 3 of a div -> busy=0, HI=LO=0 next cycle, and no later update.
  - mfhi/mflo after completion -> MDUresult equals HI/LO; MDUop=0 -> MDUresult=0.

Source files
------------

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit for the E stage.
// Owns HI/LO; the result is computed at accept and committed when busy falls.
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       MDUop,
    input  logic             start,
    input  logic             req,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MDUresult
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   pend_hi;
    logic [WIDTH-1:0]   pend_lo;
    logic               pend_we;

    logic               is_mult;
    logic               is_div;
    logic               signed_op;
    logic               accept;
    logic [2*WIDTH-1:0] ax;
    logic [2*WIDTH-1:0] bx;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   ua;
    logic [WIDTH-1:0]   ub;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   r;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        is_mult   = (MDUop == 4'd1) || (MDUop == 4'd2);
        is_div    = (MDUop == 4'd3) || (MDUop == 4'd4);
        signed_op = (MDUop == 4'd1) || (MDUop == 4'd3);

        ax   = signed_op ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
        bx   = signed_op ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
        prod = ax * bx;

        // Signed divide on magnitudes; MIN/-1 wraps back to MIN naturally.
        neg_q = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
        neg_r = signed_op && A[WIDTH-1];
        ua    = (signed_op && A[WIDTH-1]) ? -A : A;
        ub    = (signed_op && B[WIDTH-1]) ? -B : B;
        dvs   = (ub == '0) ? WIDTH'(1) : ub;
        q     = ua / dvs;
        r     = ua % dvs;

        res_hi = is_mult ? prod[2*WIDTH-1:WIDTH] : (neg_r ? -r : r);
        res_lo = is_mult ? prod[WIDTH-1:0] : (neg_q ? -q : q);
    end

    assign busy   = (cnt != '0);
    assign accept = start && !busy && !req && (is_mult || is_div);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            HI      <= '0;
            LO      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_we <= !(is_div && (B == '0));
            end else if (busy) begin
                cnt <= cnt - CW'(1);
                if ((cnt == CW'(1)) && pend_we) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
            end
            if (!busy && !req && (MDUop == 4'd7)) begin
                HI <= A;
            end
            if (!busy && !req && (MDUop == 4'd8)) begin
                LO <= A;
            end
        end
    end

    always_comb begin
        unique case (MDUop)
            4'd5:    MDUresult = HI;
            4'd6:    MDUresult = LO;
            default: MDUresult = '0;
        endcase
    end

endmodule
